ram_fifo_ctrl: RTL and testbench

- Pointer/flag controller placed directly upstream of random_accsess_memory: it drives that RAM's write/datain/addr_w/read/addr_r ports and consumes its dataout.
- Together the pair forms a synchronous FIFO (default 16 x 6) for producer/consumer stages.
- The block holds no data storage itself; it manages pointers, occupancy, flags, and the read-valid timing matched to the RAM's registered output.

---
 rtl/ram_fifo_ctrl.sv | 141 ++++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: pointer, occupancy and flag controller that sits in front of
// an external single-clock RAM with a registered read port. The controller and
// the RAM together form a synchronous FIFO. This block stores no data. It
// steers write and read addresses, counts words, raises status flags, and
// marks the cycle in which the RAM's registered output holds a popped word.
module ram_fifo_ctrl #(
    parameter int DEPTH       = 16,
    parameter int WIDTH       = 6,
    parameter int AW          = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [AW:0]      count,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             overflow,
    output logic             underflow,
    output logic             ram_write,
    output logic [WIDTH-1:0] ram_datain,
    output logic [AW-1:0]    ram_addr_w,
    output logic             ram_read,
    output logic [AW-1:0]    ram_addr_r,
    input  logic [WIDTH-1:0] ram_dataout
);

    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AFULL = (AW+1)'(AFULL_LEVEL);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);

    // Registered state
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_r;
    logic          empty_r;
    logic          afull_r;
    logic          rd_valid_r;
    logic          overflow_r;
    logic          underflow_r;

    // Combinational helpers
    logic          push_ok_s;
    logic          pop_ok_s;
    logic [AW:0]   count_nxt_s;
    logic [AW-1:0] wr_ptr_nxt_s;
    logic [AW-1:0] rd_ptr_nxt_s;

    // A push is refused when full even if a pop is accepted on the same edge.
    // A pop is refused when empty, so a push into an empty FIFO is never
    // returned on that same edge. Because full and empty cannot both hold,
    // the RAM never sees a read and a write to one address on one edge.
    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop  & ~empty_r;

    // The RAM ports are driven straight from the accept decisions and the
    // current pointers. The read data passes through from the RAM unchanged.
    assign ram_write  = push_ok_s;
    assign ram_addr_w = wr_ptr_r;
    assign ram_datain = push_data;
    assign ram_read   = pop_ok_s;
    assign ram_addr_r = rd_ptr_r;
    assign rd_data    = ram_dataout;

    assign full        = full_r;
    assign empty       = empty_r;
    assign almost_full = afull_r;
    assign count       = count_r;
    assign rd_valid    = rd_valid_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

    // Next occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Next pointers. DEPTH is a power of two, so the wrap is natural overflow.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        case (push_ok_s)
            1'b1:    wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            default: wr_ptr_nxt_s = wr_ptr_r;
        endcase
        case (pop_ok_s)
            1'b1:    rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            default: rd_ptr_nxt_s = rd_ptr_r;
        endcase
    end

    // Pointer, occupancy and flag registers. Each flag is loaded from the
    // next count, so it matches the registered count in every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == CNT_DEPTH);
            empty_r  <= (count_nxt_s == CNT_ZERO);
            afull_r  <= (count_nxt_s >= CNT_AFULL);
        end
    end

    // Read-valid tracks the RAM's one-cycle read latency. Overflow and
    // underflow are one-cycle pulses for refused requests. A reset drops any
    // read that is in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            rd_valid_r  <= pop_ok_s;
            overflow_r  <= push & full_r;
            underflow_r <= pop & empty_r;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl. A behavioural RAM with a registered read port
// stands in for the real memory. The checks cover:
//   - a directed vector table,
//   - hand-written corner sequences,
//   - randomized traffic compared against a queue reference model.
module tb_ram_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int WIDTH = 6;
    localparam int AW    = 4;
    localparam int AFULL = 12;

    logic             clock;
    logic             reset_n;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [AW:0]      count;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             overflow;
    logic             underflow;
    logic             ram_write;
    logic [WIDTH-1:0] ram_datain;
    logic [AW-1:0]    ram_addr_w;
    logic             ram_read;
    logic [AW-1:0]    ram_addr_r;
    logic [WIDTH-1:0] ram_dataout;

    int total = 0;
    int bad   = 0;

    ram_fifo_ctrl #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .AFULL_LEVEL(AFULL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .push(push), .push_data(push_data),
        .pop(pop), .full(full), .empty(empty), .almost_full(almost_full),
        .count(count), .rd_valid(rd_valid), .rd_data(rd_data),
        .overflow(overflow), .underflow(underflow), .ram_write(ram_write),
        .ram_datain(ram_datain), .ram_addr_w(ram_addr_w), .ram_read(ram_read),
        .ram_addr_r(ram_addr_r), .ram_dataout(ram_dataout)
    );

    // Behavioural RAM: synchronous write, registered read
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (ram_write) mem[ram_addr_w] <= ram_datain;
        if (ram_read)  ram_dataout <= mem[ram_addr_r];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic [WIDTH-1:0] d, input logic q);
        push = p; push_data = d; pop = q;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        push = 1'b0; pop = 1'b0; push_data = '0;
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic             push;
        logic [WIDTH-1:0] data;
        logic             pop;
        logic             exp_wr;
        logic             exp_rd;
        logic [AW-1:0]    exp_aw;
        logic [AW-1:0]    exp_ar;
        logic [AW:0]      exp_cnt;
        logic             exp_empty;
        logic             exp_rdv;
        logic [WIDTH-1:0] exp_rdata;
        logic             exp_uf;
    } vec_t;

    vec_t vecs [9];

    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] exp_d;
    int               popped;

    initial begin
        // Columns: push, data, pop | wr, rd, addr_w, addr_r, count, empty, rd_valid, rd_data, underflow
        vecs[0] = '{1'b1, 6'd2,  1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 5'd1, 1'b0, 1'b0, 6'd0,  1'b0};
        vecs[1] = '{1'b1, 6'd10, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 5'd2, 1'b0, 1'b0, 6'd0,  1'b0};
        vecs[2] = '{1'b1, 6'd7,  1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 5'd3, 1'b0, 1'b0, 6'd0,  1'b0};
        vecs[3] = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 4'd3, 4'd0, 5'd2, 1'b0, 1'b1, 6'd2,  1'b0};
        vecs[4] = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 4'd3, 4'd1, 5'd1, 1'b0, 1'b1, 6'd10, 1'b0};
        vecs[5] = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 4'd3, 4'd2, 5'd0, 1'b1, 1'b1, 6'd7,  1'b0};
        vecs[6] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 5'd0, 1'b1, 1'b0, 6'd0,  1'b0};
        vecs[7] = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 5'd0, 1'b1, 1'b0, 6'd0,  1'b1};
        vecs[8] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 5'd0, 1'b1, 1'b0, 6'd0,  1'b0};

        push = 1'b0; pop = 1'b0; push_data = '0; reset_n = 1'b0;
        #12;
        // Outputs while reset is held
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_count", count, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Directed vector table: three pushes, three pops, pop while empty
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].push, vecs[i].data, vecs[i].pop);
            check("vec_ram_write", ram_write, vecs[i].exp_wr);
            check("vec_ram_read", ram_read, vecs[i].exp_rd);
            if (vecs[i].exp_wr) check("vec_addr_w", ram_addr_w, vecs[i].exp_aw);
            if (vecs[i].exp_rd) check("vec_addr_r", ram_addr_r, vecs[i].exp_ar);
            tick();
            check("vec_count", count, vecs[i].exp_cnt);
            check("vec_empty", empty, vecs[i].exp_empty);
            check("vec_rd_valid", rd_valid, vecs[i].exp_rdv);
            if (vecs[i].exp_rdv) check("vec_rd_data", rd_data, vecs[i].exp_rdata);
            check("vec_underflow", underflow, vecs[i].exp_uf);
        end

        // Fill to full; almost_full from count 12 on
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, WIDTH'(i), 1'b0);
            check("fill_ram_write", ram_write, 1);
            check("fill_addr_w", ram_addr_w, i);
            tick();
            check("fill_count", count, i + 1);
            check("fill_afull", almost_full, (i + 1 >= AFULL) ? 1 : 0);
            check("fill_full", full, (i + 1 == DEPTH) ? 1 : 0);
        end
        // 17th push is refused
        drive(1'b1, 6'd63, 1'b0);
        check("ovf_ram_write", ram_write, 0);
        tick();
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);
        // Full with push and pop: pop accepted, push refused
        drive(1'b1, 6'd20, 1'b1);
        check("fpp_ram_write", ram_write, 0);
        check("fpp_ram_read", ram_read, 1);
        check("fpp_addr_r", ram_addr_r, 0);
        tick();
        check("fpp_overflow", overflow, 1);
        check("fpp_rd_valid", rd_valid, 1);
        check("fpp_rd_data", rd_data, 0);
        check("fpp_count", count, 15);
        check("fpp_full", full, 0);
        drive(1'b0, 6'd0, 1'b0);
        tick();
        check("fpp_ovf_clear", overflow, 0);
        check("fpp_rdv_clear", rd_valid, 0);

        // Empty with push and pop: pop refused, push accepted
        do_reset();
        drive(1'b1, 6'd11, 1'b1);
        check("epp_ram_read", ram_read, 0);
        check("epp_ram_write", ram_write, 1);
        tick();
        check("epp_underflow", underflow, 1);
        check("epp_count", count, 1);
        check("epp_rd_valid", rd_valid, 0);
        drive(1'b0, 6'd0, 1'b1);
        check("epp_pop_read", ram_read, 1);
        tick();
        check("epp_pop_valid", rd_valid, 1);
        check("epp_pop_data", rd_data, 11);
        check("epp_pop_count", count, 0);
        check("epp_uf_clear", underflow, 0);

        // Randomized traffic against a queue reference model
        do_reset();
        q.delete();
        popped = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int  pp;
            int  old_size;
            logic p, r, acc_p, acc_r;
            logic [WIDTH-1:0] d;
            pp = ((cyc / 25) % 2 == 0) ? 80 : 20;
            p = ($urandom_range(0, 99) < pp);
            r = ($urandom_range(0, 99) < (100 - pp));
            d = WIDTH'($urandom_range(0, 63));
            old_size = q.size();
            acc_p = p && (old_size < DEPTH);
            acc_r = r && (old_size > 0);
            if (acc_r) begin
                exp_d = q.pop_front();
                popped++;
            end
            if (acc_p) q.push_back(d);
            drive(p, d, r);
            tick();
            check("rnd_count", count, q.size());
            check("rnd_rd_valid", rd_valid, acc_r);
            if (acc_r) check("rnd_rd_data", rd_data, exp_d);
            check("rnd_overflow", overflow, (p && old_size == DEPTH) ? 1 : 0);
            check("rnd_underflow", underflow, (r && old_size == 0) ? 1 : 0);
            check("rnd_full", full, (q.size() == DEPTH) ? 1 : 0);
            check("rnd_empty", empty, (q.size() == 0) ? 1 : 0);
            check("rnd_afull", almost_full, (q.size() >= AFULL) ? 1 : 0);
        end
        check("rnd_popped_40", (popped >= 40) ? 1 : 0, 1);

        // Reset asserted while a popped word is being presented
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, WIDTH'(5 + i), 1'b0);
            tick();
        end
        drive(1'b0, 6'd0, 1'b1);
        tick();
        check("midrst_pre_valid", rd_valid, 1);
        check("midrst_pre_data", rd_data, 5);
        reset_n = 1'b0;
        #1;
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        pop = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("midrst_after_valid", rd_valid, 0);
        check("midrst_after_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
